// File: rtl/decoder_pkg.sv
// Shared types and constants for the one-hot decoder (and, later, its matching encoder).
package decoder_pkg;

    localparam int CODE_W   = 4;
    localparam int ONEHOT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic logic [ONEHOT_W-1:0] onehot_of(input logic [CODE_W-1:0] code);
        return ONEHOT_W'(1) << code;
    endfunction

endpackage

// File: rtl/down_counter.sv
// Loadable down counter with a zero flag; times both the hold and the gap phases.
module down_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/decoder_pulse_gen.sv
// Sequential 4-to-16 decoder: accepts a code, holds its one-hot line for HOLD_CYCLES, then idles GAP_CYCLES.
module decoder_pulse_gen
    import decoder_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [CODE_W-1:0]   input_wire,
    input  logic                input_valid,
    output logic                input_ready,
    output logic [ONEHOT_W-1:0] output_wire,
    output logic                output_valid,
    output logic                done,
    output logic                busy
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t                state_q, state_d;
    logic [ONEHOT_W-1:0]   out_d;
    logic                  valid_d;
    logic                  done_d;
    logic                  cnt_load;
    logic [CNT_W-1:0]      cnt_load_value;
    logic                  cnt_dec;
    logic                  cnt_zero;

    down_counter #(.CNT_W(CNT_W)) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    assign input_ready = enable && (state_q == IDLE);
    assign busy        = (state_q != IDLE);

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        out_d          = output_wire;
        valid_d        = output_valid;
        done_d         = 1'b0;
        cnt_load       = 1'b0;
        cnt_load_value = '0;
        cnt_dec        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (input_valid && input_ready) begin
                    state_d        = HOLD;
                    out_d          = onehot_of(input_wire);
                    valid_d        = 1'b1;
                    cnt_load       = 1'b1;
                    cnt_load_value = HOLD_LOAD;
                end
            end
            HOLD: begin
                // Abort takes priority over a normal finish and never raises done.
                if (!enable) begin
                    state_d = IDLE;
                    out_d   = '0;
                    valid_d = 1'b0;
                end else if (cnt_zero) begin
                    out_d   = '0;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_d        = GAP;
                        cnt_load       = 1'b1;
                        cnt_load_value = GAP_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                out_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: the asynchronous reset clears every register, so outputs read zero before any clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            output_wire  <= '0;
            output_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            output_wire  <= out_d;
            output_valid <= valid_d;
            done         <= done_d;
        end
    end

endmodule
